// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcode bit positions,
// write-back select encoding, FSM states and the debug view of the stage.
package mem_stage_pkg;

  localparam int OP_REGWRITE = 5;
  localparam int OP_MEMREAD  = 4;
  localparam int OP_MEMWRITE = 3;
  localparam int OP_WBSEL_HI = 2;
  localparam int OP_WBSEL_LO = 1;

  // The wait counter is sized for the largest supported WAIT_LIMIT (255).
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wbsel_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       ex_mem_op;
  } mem_dbg_t;

endpackage

// File: rtl/mem_stage_ex_mem_reg.sv
// EX/MEM pipeline register: loads every non-stalled edge, holds while stalled,
// clears asynchronously on active-low reset.
module ex_mem_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic [5:0]        op_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        dst_i,
  output logic [5:0]        op_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [4:0]        dst_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_o    <= '0;
      pc4_o   <= '0;
      alu_o   <= '0;
      wdata_o <= '0;
      dst_o   <= '0;
    end else if (!stall_i) begin
      op_o    <= op_i;
      pc4_o   <= pc4_i;
      alu_o   <= alu_i;
      wdata_o <= wdata_i;
      dst_o   <= dst_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, variable-latency data-memory access
// FSM with timeout, MEM/WB register and the forwarding values for EX.
//
// Handshake: dmem_req is held high with stable we/addr/wdata until the cycle
// dmem_ready is seen (load data valid that cycle) or the access times out.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        EX_MEM_OpCode,
  input  logic [DATA_W-1:0] PC_plus4_in,
  input  logic [DATA_W-1:0] ALUout_in,
  input  logic [DATA_W-1:0] Write_Data_in,
  input  logic [4:0]        RegWriteDst_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] ALUout_prev,
  output logic [DATA_W-1:0] MemtoReg,
  output logic              WB_RegWrite,
  output logic [4:0]        WB_Dst,
  output logic              EX_MEM_RegWrite,
  output logic [4:0]        EX_MEM_Dst,
  output logic              err_misalign,
  output logic              err_timeout,
  output mem_dbg_t          dbg
);

  logic [5:0]        op_q;
  logic [DATA_W-1:0] pc4_q, alu_q, wdata_q;
  logic [4:0]        dst_q;

  ex_mem_reg #(.DATA_W(DATA_W)) u_ex_mem (
    .clk     (clk),
    .rst_n   (reset),
    .stall_i (stall),
    .op_i    (EX_MEM_OpCode),
    .pc4_i   (PC_plus4_in),
    .alu_i   (ALUout_in),
    .wdata_i (Write_Data_in),
    .dst_i   (RegWriteDst_in),
    .op_o    (op_q),
    .pc4_o   (pc4_q),
    .alu_o   (alu_q),
    .wdata_o (wdata_q),
    .dst_o   (dst_q)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_dst_q, wb_dst_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic       access, misalign, timeout, suppressed;
  logic [1:0] wbsel;

  assign access   = op_q[OP_MEMREAD] | op_q[OP_MEMWRITE];
  assign misalign = access & (alu_q[1:0] != 2'b00);
  assign wbsel    = op_q[OP_WBSEL_HI:OP_WBSEL_LO];

  // cnt_q counts completed WAIT cycles; the current one is the last allowed
  // when cnt_q == WAIT_LIMIT-1. Ready on that cycle still wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    stall    = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !misalign) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
          dmem_req = 1'b0;
          timeout  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign suppressed = misalign | timeout;

  always_comb begin
    wb_we_d   = 1'b0;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    if (!stall) begin
      wb_we_d  = op_q[OP_REGWRITE] & ~suppressed;
      wb_dst_d = dst_q;
      case (wbsel)
        WB_MEM:  wb_data_d = dmem_rdata;
        WB_PC4:  wb_data_d = pc4_q;
        default: wb_data_d = alu_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_we_q   <= wb_we_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
    end
  end

  // A store wins when both MemRead and MemWrite are set.
  assign dmem_we         = op_q[OP_MEMWRITE];
  assign dmem_addr       = alu_q;
  assign dmem_wdata      = wdata_q;
  assign ALUout_prev     = alu_q;
  assign MemtoReg        = wb_data_q;
  assign WB_RegWrite     = wb_we_q;
  assign WB_Dst          = wb_dst_q;
  assign EX_MEM_RegWrite = op_q[OP_REGWRITE];
  assign EX_MEM_Dst      = dst_q;
  assign err_misalign    = misalign;
  assign err_timeout     = timeout;

  assign dbg = '{state: state_q, wait_cnt: cnt_q, ex_mem_op: op_q};

endmodule
